// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state encoding and the ALU combinational function
// shared by exec_unit_iter and its multiply/divide datapath.
package exec_pkg;

    // Widest operand the ALU function handles; exec_unit_iter left-justifies
    // its WIDTH-bit operands into this width so one function serves all widths.
    localparam int MAX_W = 64;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DIV   = 2'd3
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             overflow;
    } alu_out_t;

    // Operands arrive left-justified (real bits at the top, pad zeros below),
    // so the sign bit and carry-out of the WIDTH-bit operation sit at bit
    // MAX_W-1 and signed overflow / SLT fall out of plain 64-bit arithmetic.
    // The returned result is right-aligned: bits above WIDTH are zero.
    function automatic alu_out_t alu_fn(input logic [3:0]       op,
                                        input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input int               pad);
        alu_out_t         o;
        logic [MAX_W-1:0] r;
        logic             lt;
        o  = '0;
        r  = '0;
        lt = $signed(a) < $signed(b);
        case (op)
            OP_ADD: begin
                r          = a + b;
                o.overflow = (a[MAX_W-1] == b[MAX_W-1]) && (r[MAX_W-1] != a[MAX_W-1]);
            end
            OP_SUB: begin
                r          = a - b;
                o.overflow = (a[MAX_W-1] != b[MAX_W-1]) && (r[MAX_W-1] != a[MAX_W-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        if (op == OP_SLT) begin
            o.result = {{(MAX_W-1){1'b0}}, lt};
        end else begin
            o.result = r >> pad;
        end
        return o;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: shared shift register datapath for unsigned shift-add multiply
// and unsigned restoring divide, WIDTH iterations per operation.
// hi/lo present the value the registers take on the current step; the parent
// samples them in the cycle finish is high (the last iteration).
module iter_muldiv
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             finish
);

    localparam int CW = $clog2(WIDTH) + 1;

    // hi_r: partial product / partial remainder; lo_r: multiplier / quotient.
    // opd_r holds the multiplicand for MULTU and the divisor for DIVU.
    logic [WIDTH-1:0] hi_r, lo_r, opd_r;
    logic             div_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum, rem_sh, trial;

    // One iteration of either algorithm.
    always_comb begin
        sum    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : '0);
        rem_sh = {hi_r, lo_r[WIDTH-1]};
        trial  = rem_sh - {1'b0, opd_r};
        if (div_r) begin
            if (!trial[WIDTH]) begin
                hi = trial[WIDTH-1:0];
                lo = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi = rem_sh[WIDTH-1:0];
                lo = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi = sum[WIDTH:1];
            lo = {sum[0], lo_r[WIDTH-1:1]};
        end
    end

    assign finish = (cnt == CW'(1));

    // Load on go, then iterate while the counter is non-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r  <= '0;
            lo_r  <= '0;
            opd_r <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
        end else if (go) begin
            hi_r  <= '0;
            lo_r  <= is_div ? a : b;
            opd_r <= is_div ? b : a;
            div_r <= is_div;
            cnt   <= CW'(WIDTH);
        end else if (cnt != '0) begin
            hi_r <= hi;
            lo_r <= lo;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/exec_unit_iter.sv
// exec_unit_iter: ALU, shift, MULTU and DIVU execution unit with a
// start/busy/done handshake.
// Build option: EXEC_FAST_SHIFT_EN replaces the 1-bit/cycle shifter with a
// combinational barrel shifter so shifts finish like single-cycle ops.
//
// Handshake: start is sampled only while busy is low (FSM in IDLE); the edge
// that samples start=1 accepts the op and captures op/operands/shamt. busy is
// high from the next cycle until the cycle before done. done is a one-cycle
// pulse, coincident with the FSM being back in IDLE, during which result,
// hi/lo and flags are valid and a new start may already be presented.
// Flags update on every done except for reserved opcodes; zero is only
// meaningful for ALU/shift ops and reads 0 after MULTU/DIVU.
module exec_unit_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             zero,
    output logic             div0
);

    localparam int PAD = MAX_W - WIDTH;

    state_t           state, state_next;
    alu_out_t         alu_o;
    logic             alu_zero;
    logic             done_next, res_wr, res_ovf, res_zero, md_wr, dz_wr, md_go;
    logic [WIDTH-1:0] res_val, md_hi, md_lo;
    logic             md_finish;

`ifdef EXEC_FAST_SHIFT_EN
    logic [WIDTH-1:0] shift_fast;
`else
    logic             sh_load;
    logic [WIDTH-1:0] sh_val, sh_step;
    logic [SHW-1:0]   sh_cnt;
    logic [3:0]       sh_op;
`endif

    // Single-cycle ALU result computed straight from the inputs at accept.
    always_comb begin
        alu_o    = alu_fn(op, MAX_W'(src_a) << PAD, MAX_W'(src_b) << PAD, PAD);
        alu_zero = (alu_o.result == '0);
    end

`ifdef EXEC_FAST_SHIFT_EN
    // Barrel shifter used at accept time.
    always_comb begin
        case (op)
            OP_SLL:  shift_fast = src_b << shamt;
            OP_SRL:  shift_fast = src_b >> shamt;
            default: shift_fast = $signed(src_b) >>> shamt;
        endcase
    end
`else
    // One-bit step of the iterative shifter; SRA replicates the MSB.
    always_comb begin
        case (sh_op)
            OP_SLL:  sh_step = sh_val << 1;
            OP_SRL:  sh_step = sh_val >> 1;
            default: sh_step = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
        endcase
    end
`endif

    iter_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .reset  (reset),
        .go     (md_go),
        .is_div (op == OP_DIVU),
        .a      (src_a),
        .b      (src_b),
        .hi     (md_hi),
        .lo     (md_lo),
        .finish (md_finish)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle register-write controls.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        res_wr     = 1'b0;
        res_val    = '0;
        res_ovf    = 1'b0;
        res_zero   = 1'b0;
        md_wr      = 1'b0;
        dz_wr      = 1'b0;
        md_go      = 1'b0;
`ifndef EXEC_FAST_SHIFT_EN
        sh_load    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    done_next = 1'b1;
                    if (op <= OP_SLT) begin
                        res_wr   = 1'b1;
                        res_val  = alu_o.result[WIDTH-1:0];
                        res_ovf  = alu_o.overflow;
                        res_zero = alu_zero;
                    end else if (op == OP_SLL || op == OP_SRL || op == OP_SRA) begin
`ifdef EXEC_FAST_SHIFT_EN
                        res_wr   = 1'b1;
                        res_val  = shift_fast;
                        res_zero = (shift_fast == '0);
`else
                        if (shamt == '0) begin
                            res_wr   = 1'b1;
                            res_val  = src_b;
                            res_zero = (src_b == '0);
                        end else begin
                            done_next  = 1'b0;
                            sh_load    = 1'b1;
                            state_next = ST_SHIFT;
                        end
`endif
                    end else if (op == OP_MULTU) begin
                        done_next  = 1'b0;
                        md_go      = 1'b1;
                        state_next = ST_MUL;
                    end else if (op == OP_DIVU) begin
                        if (src_b == '0) begin
                            dz_wr = 1'b1;
                        end else begin
                            done_next  = 1'b0;
                            md_go      = 1'b1;
                            state_next = ST_DIV;
                        end
                    end
                    // reserved opcodes: done only, nothing else written
                end
            end
`ifndef EXEC_FAST_SHIFT_EN
            ST_SHIFT: begin
                if (sh_cnt == SHW'(1)) begin
                    res_wr     = 1'b1;
                    res_val    = sh_step;
                    res_zero   = (sh_step == '0);
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_MUL, ST_DIV: begin
                if (md_finish) begin
                    md_wr      = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifndef EXEC_FAST_SHIFT_EN
    // Iterative shifter: capture at accept, one bit per cycle in SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_val <= '0;
            sh_cnt <= '0;
            sh_op  <= '0;
        end else if (sh_load) begin
            sh_val <= src_b;
            sh_cnt <= shamt;
            sh_op  <= op;
        end else if (state == ST_SHIFT) begin
            sh_val <= sh_step;
            sh_cnt <= sh_cnt - SHW'(1);
        end
    end
`endif

    // Output registers: result/hi/lo/flags persist until the next done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done     <= 1'b0;
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= done_next;
            if (res_wr) begin
                result   <= res_val;
                overflow <= res_ovf;
                zero     <= res_zero;
                div0     <= 1'b0;
            end
            if (md_wr) begin
                hi       <= md_hi;
                lo       <= md_lo;
                overflow <= 1'b0;
                zero     <= 1'b0;
                div0     <= 1'b0;
            end
            if (dz_wr) begin
                overflow <= 1'b0;
                zero     <= 1'b0;
                div0     <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_unit_iter.sv
// tb_exec_unit_iter: directed and randomized stimulus for exec_unit_iter with
// a scoreboard queue filled by a reference model and emptied by a monitor.
module tb_exec_unit_iter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic [SW-1:0] shamt;
    logic          busy, done, overflow, zero, div0;
    logic [W-1:0]  result, hi, lo;

    exec_unit_iter #(.WIDTH(W), .SHW(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .lo       (lo),
        .overflow (overflow),
        .zero     (zero),
        .div0     (div0)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
        logic         zero;
        logic         div0;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_result, m_hi, m_lo;
    logic         m_ovf, m_zero, m_div0;

    task automatic model_reset();
        m_result = '0; m_hi = '0; m_lo = '0;
        m_ovf = 1'b0; m_zero = 1'b0; m_div0 = 1'b0;
    endtask

    task automatic set_alu(input logic [W-1:0] r, input logic v);
        m_result = r;
        m_ovf    = v;
        m_zero   = (r == '0);
        m_div0   = 1'b0;
    endtask

    function automatic int shift_lat(input logic [SW-1:0] s);
`ifdef EXEC_FAST_SHIFT_EN
        return 1;
`else
        return (s == '0) ? 1 : int'(s) + 1;
`endif
    endfunction

    task automatic predict(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SW-1:0] s, input int issue_cyc);
        exp_t           e;
        longint         sa, sb, sr, lim;
        logic [2*W-1:0] p;
        int             lat;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) <<< (W - 1);
        lat = 1;
        case (o)
            4'd0: begin sr = sa + sb; set_alu(W'(sr), (sr >= lim) || (sr < -lim)); end
            4'd1: begin sr = sa - sb; set_alu(W'(sr), (sr >= lim) || (sr < -lim)); end
            4'd2: set_alu(a & b, 1'b0);
            4'd3: set_alu(a | b, 1'b0);
            4'd4: set_alu(a ^ b, 1'b0);
            4'd5: set_alu(~(a | b), 1'b0);
            4'd6: set_alu(W'(sa < sb), 1'b0);
            4'd7: begin set_alu(b << s, 1'b0); lat = shift_lat(s); end
            4'd8: begin set_alu(b >> s, 1'b0); lat = shift_lat(s); end
            4'd9: begin set_alu($signed(b) >>> s, 1'b0); lat = shift_lat(s); end
            4'd10: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
                m_ovf = 1'b0; m_zero = 1'b0; m_div0 = 1'b0;
                lat = W + 1;
            end
            4'd11: begin
                m_ovf = 1'b0; m_zero = 1'b0;
                if (b == '0) begin
                    m_div0 = 1'b1;
                end else begin
                    m_lo = a / b; m_hi = a % b; m_div0 = 1'b0;
                    lat = W + 1;
                end
            end
            default: ;
        endcase
        e.result = m_result; e.hi = m_hi; e.lo = m_lo;
        e.ovf = m_ovf; e.zero = m_zero; e.div0 = m_div0;
        e.done_cyc = issue_cyc + lat;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                chk("result", 64'(result), 64'(mon_e.result));
                chk("hi", 64'(hi), 64'(mon_e.hi));
                chk("lo", 64'(lo), 64'(mon_e.lo));
                chk("overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
                chk("zero", {63'd0, zero}, {63'd0, mon_e.zero});
                chk("div0", {63'd0, div0}, {63'd0, mon_e.div0});
                chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic noise();
        start = 1'($urandom_range(0, 1));
        op    = 4'($urandom_range(0, 15));
        src_a = $urandom;
        src_b = $urandom;
        shamt = SW'($urandom_range(0, 31));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] s);
        int g = 0;
        while (busy && g < 200) begin
            noise();
            @(negedge clk);
            g++;
        end
        if (busy) chk("issue_timeout_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = o; src_a = a; src_b = b; shamt = s;
        predict(o, a, b, s, cyc);
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom_range(0, 15));
        src_a = $urandom;
        src_b = $urandom;
        shamt = SW'($urandom_range(0, 31));
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 400) begin
            if (busy) noise();
            else start = 1'b0;
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        if (g >= 400) begin
            chk("drain_timeout_busy", {63'd0, busy}, 64'd0);
            chk("drain_timeout_queue", 64'(exp_q.size()), 64'd0);
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; shamt = '0;
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_flags", {61'd0, overflow, zero, div0}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, '0);
        drain();
        chk("add_ovf_result", 64'(result), 64'h8000_0000);
        chk("add_ovf_flag", {62'd0, overflow, zero}, 64'b10);

        issue(4'd1, 32'd5, 32'd5, '0);
        drain();
        chk("sub_zero", {31'd0, zero, result}, 64'h1_0000_0000);

        issue(4'd6, 32'hFFFF_FFFF, 32'd1, '0);
        drain();
        chk("slt_neg", 64'(result), 64'd1);

        issue(4'd9, 32'd0, 32'h8000_0000, 5'd4);
        drain();
        chk("sra_by4", 64'(result), 64'hF800_0000);

        issue(4'd7, 32'd0, 32'h0000_1234, 5'd0);
        issue(4'd8, 32'd0, 32'h8000_0001, 5'd31);
        issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
        drain();
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        issue(4'd11, 32'd100, 32'd7, '0);
        drain();
        chk("divu_q_r", {hi, lo}, {32'd2, 32'd14});

        issue(4'd11, 32'd55, 32'd0, '0);
        drain();
        chk("divu0_flag", {63'd0, div0}, 64'd1);
        chk("divu0_hilo_kept", {hi, lo}, {32'd2, 32'd14});

        issue(4'd13, 32'd1, 32'd2, 5'd3);
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, '0);
        drain();

        // reset in the middle of a division: no done, everything cleared
        issue(4'd11, 32'd1000, 32'd3, '0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("midrst_outputs", {result, hi}, 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_ctrl", {59'd0, busy, done, overflow, zero, div0}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", {63'd0, done}, 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        issue(4'd0, 32'd2, 32'd3, '0);
        drain();
        chk("post_rst_add", 64'(result), 64'd5);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), SW'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
